// File: rtl/arb_pkg.sv
// Shared types and default widths for the I/D cache-to-memory arbiter.
package arb_pkg;

  localparam int LINE_W_DEFAULT = 128;
  localparam int ADDR_W_DEFAULT = 16;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2
  } state_t;

  typedef enum logic {
    REQ_I = 1'b0,
    REQ_D = 1'b1
  } requester_t;

endpackage

// File: rtl/arb_select.sv
// Winner selection between I and D requesters.
// ARB_ROUND_ROBIN_EN adds a last-served pointer; otherwise D has fixed priority.
module arb_select
  import arb_pkg::*;
(
`ifdef ARB_ROUND_ROBIN_EN
  input  logic       clk,
  input  logic       rst_n,
  input  logic       grant_en,
`endif
  input  logic       i_req,
  input  logic       d_req,
  output logic       any_req,
  output requester_t winner
);

  assign any_req = i_req | d_req;

`ifdef ARB_ROUND_ROBIN_EN
  requester_t last_q, last_d;

  // On a tie, grant whoever was not served last.
  always_comb begin
    winner = REQ_I;
    if (i_req && d_req) begin
      winner = (last_q == REQ_I) ? REQ_D : REQ_I;
    end else if (d_req) begin
      winner = REQ_D;
    end
  end

  always_comb begin
    last_d = last_q;
    if (grant_en) begin
      last_d = winner;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= REQ_D;
    end else begin
      last_q <= last_d;
    end
  end
`else
  always_comb begin
    winner = d_req ? REQ_D : REQ_I;
  end
`endif

endmodule

// File: rtl/cache_arbiter.sv
// Arbitrates I-cache and D-cache line requests onto one memory port.
// Tie policy set by ARB_ROUND_ROBIN_EN (round robin) or its absence (D first).
module cache_arbiter
  import arb_pkg::*;
#(
  parameter int LINE_W = LINE_W_DEFAULT,
  parameter int ADDR_W = ADDR_W_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_read,
  input  logic              i_write,
  input  logic [ADDR_W-1:0] i_address,
  input  logic [LINE_W-1:0] i_wdata,
  output logic              i_resp,
  output logic [LINE_W-1:0] i_rdata,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_address,
  input  logic [LINE_W-1:0] d_wdata,
  output logic              d_resp,
  output logic [LINE_W-1:0] d_rdata,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_address,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic              mem_resp,
  input  logic [LINE_W-1:0] mem_rdata
);

  state_t            state_q, state_d;
  logic              rd_q, rd_d, wr_q, wr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LINE_W-1:0] wdata_q, wdata_d;
  logic              any_req;
  requester_t        winner;

  arb_select u_select (
`ifdef ARB_ROUND_ROBIN_EN
    .clk      (clk),
    .rst_n    (rst_n),
    .grant_en (state_q == IDLE && any_req),
`endif
    .i_req    (i_read | i_write),
    .d_req    (d_read | d_write),
    .any_req  (any_req),
    .winner   (winner)
  );

  // Read+write together on one requester resolves to a write.
  always_comb begin
    state_d = state_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    i_resp  = 1'b0;
    d_resp  = 1'b0;
    case (state_q)
      IDLE: begin
        if (any_req) begin
          if (winner == REQ_D) begin
            state_d = SERVE_D;
            wr_d    = d_write;
            rd_d    = d_read & ~d_write;
            addr_d  = d_address;
            wdata_d = d_wdata;
          end else begin
            state_d = SERVE_I;
            wr_d    = i_write;
            rd_d    = i_read & ~i_write;
            addr_d  = i_address;
            wdata_d = i_wdata;
          end
        end
      end
      SERVE_I: begin
        if (mem_resp) begin
          i_resp  = 1'b1;
          state_d = IDLE;
        end
      end
      SERVE_D: begin
        if (mem_resp) begin
          d_resp  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  assign mem_read    = rd_q & (state_q != IDLE);
  assign mem_write   = wr_q & (state_q != IDLE);
  assign mem_address = addr_q;
  assign mem_wdata   = wdata_q;
  assign i_rdata     = mem_rdata;
  assign d_rdata     = mem_rdata;

`ifndef SYNTHESIS
  a_i_rw_exclusive: assert property (@(posedge clk) disable iff (!rst_n) !(i_read && i_write))
    else $error("cache_arbiter: i_read and i_write asserted together");
  a_d_rw_exclusive: assert property (@(posedge clk) disable iff (!rst_n) !(d_read && d_write))
    else $error("cache_arbiter: d_read and d_write asserted together");
`endif

endmodule

// File: tb/tb_cache_arbiter.sv
// Self-checking bench for cache_arbiter: vector table plus directed corner sequences.
// Expected grant order follows ARB_ROUND_ROBIN_EN when it is defined.
module tb_cache_arbiter;
  import arb_pkg::*;

  localparam int LW = 128;
  localparam int AW = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          i_read = 1'b0, i_write = 1'b0, d_read = 1'b0, d_write = 1'b0;
  logic [AW-1:0] i_address = '0, d_address = '0;
  logic [LW-1:0] i_wdata = '0, d_wdata = '0;
  logic          i_resp, d_resp;
  logic [LW-1:0] i_rdata, d_rdata;
  logic          mem_read, mem_write;
  logic [AW-1:0] mem_address;
  logic [LW-1:0] mem_wdata;
  logic          mem_resp = 1'b0;
  logic [LW-1:0] mem_rdata = '0;

  always #5 clk = ~clk;

  cache_arbiter #(.LINE_W(LW), .ADDR_W(AW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_read      (i_read),
    .i_write     (i_write),
    .i_address   (i_address),
    .i_wdata     (i_wdata),
    .i_resp      (i_resp),
    .i_rdata     (i_rdata),
    .d_read      (d_read),
    .d_write     (d_write),
    .d_address   (d_address),
    .d_wdata     (d_wdata),
    .d_resp      (d_resp),
    .d_rdata     (d_rdata),
    .mem_read    (mem_read),
    .mem_write   (mem_write),
    .mem_address (mem_address),
    .mem_wdata   (mem_wdata),
    .mem_resp    (mem_resp),
    .mem_rdata   (mem_rdata)
  );

  typedef struct {
    logic          wr;
    logic [AW-1:0] addr;
    logic [LW-1:0] wdata;
    requester_t    who;
  } txn_t;

  typedef struct {
    logic          i_rd, i_wr;
    logic [AW-1:0] i_addr;
    logic [LW-1:0] i_wd;
    logic          d_rd, d_wr;
    logic [AW-1:0] d_addr;
    logic [LW-1:0] d_wd;
    requester_t    first;
  } vec_t;

`ifdef ARB_ROUND_ROBIN_EN
  localparam requester_t TIE2 = REQ_I, TIE3 = REQ_I, TIE5 = REQ_D, TIE6 = REQ_D;
`else
  localparam requester_t TIE2 = REQ_D, TIE3 = REQ_D, TIE5 = REQ_D, TIE6 = REQ_D;
`endif

  txn_t exp_q[$];
  txn_t cur;
  int   tests_run = 0, tests_failed = 0;
  int   mem_lat = 2, lat_cnt = 0;
  bit   use_a5 = 1'b0, chk_en = 1'b1, in_txn = 1'b0, prev_resp = 1'b0, busy = 1'b0;

  task automatic checkOutput(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Memory model: answers after mem_lat cycles, data derived from the address.
  always @(negedge clk) begin
    if (!(mem_read || mem_write) || mem_resp) begin
      mem_resp  = 1'b0;
      lat_cnt   = 0;
      mem_rdata = {$urandom, $urandom, $urandom, $urandom};
    end else begin
      lat_cnt++;
      if (lat_cnt >= mem_lat) begin
        mem_resp  = 1'b1;
        mem_rdata = use_a5 ? {16{8'hA5}} : {8{mem_address}};
      end
    end
  end

  // Scoreboard: pop the expected transaction when the memory side starts one.
  always begin
    @(negedge clk);
    #1;
    if (chk_en) begin
      busy = mem_read || mem_write;
      if (busy && !in_txn) begin
        checkOutput("idle_gap", prev_resp, 1'b0);
        in_txn = 1'b1;
        if (exp_q.size() == 0) begin
          tests_run++;
          tests_failed++;
          $display("[TB] FAIL unexpected_txn: got address %h expected no transaction", mem_address);
          cur = '{mem_write, mem_address, mem_wdata, REQ_I};
        end else begin
          cur = exp_q.pop_front();
          checkOutput("txn_write", mem_write, cur.wr);
          checkOutput("txn_read", mem_read, !cur.wr);
          checkOutput("txn_address", mem_address, cur.addr);
          checkOutput("txn_wdata", mem_wdata, cur.wdata);
        end
      end else if (busy) begin
        checkOutput("hold_write", mem_write, cur.wr);
        checkOutput("hold_address", mem_address, cur.addr);
        checkOutput("hold_wdata", mem_wdata, cur.wdata);
      end else if (in_txn) begin
        tests_run++;
        tests_failed++;
        $display("[TB] FAIL txn_vanished: got idle expected address %h", cur.addr);
        in_txn = 1'b0;
      end
      if (busy && mem_resp && in_txn) begin
        checkOutput("i_resp", i_resp, cur.who == REQ_I);
        checkOutput("d_resp", d_resp, cur.who == REQ_D);
        checkOutput("rdata", (cur.who == REQ_I) ? i_rdata : d_rdata,
                    use_a5 ? {16{8'hA5}} : {8{cur.addr}});
        in_txn    = 1'b0;
        prev_resp = 1'b1;
      end else begin
        checkOutput("i_resp_quiet", i_resp, 1'b0);
        checkOutput("d_resp_quiet", d_resp, 1'b0);
        prev_resp = 1'b0;
      end
    end
  end

  task automatic applyStimulus(input vec_t v);
    txn_t ti, td;
    ti = '{v.i_wr, v.i_addr, v.i_wd, REQ_I};
    td = '{v.d_wr, v.d_addr, v.d_wd, REQ_D};
    @(negedge clk);
    #2;
    i_read = v.i_rd; i_write = v.i_wr; i_address = v.i_addr; i_wdata = v.i_wd;
    d_read = v.d_rd; d_write = v.d_wr; d_address = v.d_addr; d_wdata = v.d_wd;
    if ((v.i_rd || v.i_wr) && (v.d_rd || v.d_wr)) begin
      if (v.first == REQ_I) begin
        exp_q.push_back(ti); exp_q.push_back(td);
      end else begin
        exp_q.push_back(td); exp_q.push_back(ti);
      end
    end else if (v.i_rd || v.i_wr) begin
      exp_q.push_back(ti);
    end else if (v.d_rd || v.d_wr) begin
      exp_q.push_back(td);
    end
    for (int c = 0; c < 100 && (i_read || i_write || d_read || d_write); c++) begin
      @(negedge clk);
      #2;
      if (i_resp) begin i_read = 1'b0; i_write = 1'b0; end
      if (d_resp) begin d_read = 1'b0; d_write = 1'b0; end
    end
    if (i_read || i_write || d_read || d_write) begin
      tests_run++;
      tests_failed++;
      $display("[TB] FAIL stimulus_timeout: got requests still pending expected all served");
      i_read = 1'b0; i_write = 1'b0; d_read = 1'b0; d_write = 1'b0;
    end
  endtask

  initial begin
    vec_t vecs[7];
    vec_t post;
    int   cnt;
    bit   found;

    vecs[0] = '{1'b1, 1'b0, 16'h0040, 128'h0, 1'b0, 1'b0, 16'h0000, 128'h0, REQ_I};
    vecs[1] = '{1'b0, 1'b0, 16'h0000, 128'h0, 1'b0, 1'b1, 16'h0100, 128'h1234, REQ_D};
    vecs[2] = '{1'b1, 1'b0, 16'h0080, 128'h0, 1'b0, 1'b1, 16'h0100, 128'h1234, TIE2};
    vecs[3] = '{1'b0, 1'b1, 16'h0300, 128'hCAFE, 1'b1, 1'b0, 16'h0400, 128'h0, TIE3};
    vecs[4] = '{1'b1, 1'b0, 16'h0500, 128'h0, 1'b0, 1'b0, 16'h0000, 128'h0, REQ_I};
    vecs[5] = '{1'b1, 1'b0, 16'h0600, 128'h0, 1'b0, 1'b1, 16'h0700, 128'h55AA, TIE5};
    vecs[6] = '{1'b1, 1'b0, 16'h0800, 128'h0, 1'b1, 1'b0, 16'h0900, 128'h0, TIE6};

    #2 rst_n = 1'b0;
    #1;
    checkOutput("reset_mem_read", mem_read, 1'b0);
    checkOutput("reset_mem_write", mem_write, 1'b0);
    checkOutput("reset_i_resp", i_resp, 1'b0);
    checkOutput("reset_d_resp", d_resp, 1'b0);
    checkOutput("reset_mem_address", mem_address, '0);
    checkOutput("reset_mem_wdata", mem_wdata, '0);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;

    for (int k = 0; k < 7; k++) applyStimulus(vecs[k]);

    // Single I read with an A5 line; mem_read must rise one cycle after the request.
    use_a5 = 1'b1;
    mem_lat = 2;
    exp_q.push_back('{1'b0, 16'h0040, '0, REQ_I});
    @(negedge clk);
    #2;
    i_read = 1'b1; i_address = 16'h0040; i_wdata = '0;
    @(negedge clk);
    #2;
    checkOutput("latency_mem_read", mem_read, 1'b1);
    checkOutput("latency_mem_address", mem_address, 16'h0040);
    found = 1'b0;
    for (int c = 0; c < 20 && !found; c++) begin
      @(negedge clk);
      #2;
      if (i_resp) begin
        found = 1'b1;
        checkOutput("a5_i_rdata", i_rdata, {16{8'hA5}});
        checkOutput("a5_d_resp", d_resp, 1'b0);
        i_read = 1'b0;
      end
    end
    checkOutput("a5_resp_seen", found, 1'b1);
    use_a5 = 1'b0;

    // D read dropped after grant still completes with one pulse.
    mem_lat = 4;
    exp_q.push_back('{1'b0, 16'h0A00, '0, REQ_D});
    @(negedge clk);
    #2;
    d_read = 1'b1; d_address = 16'h0A00; d_wdata = '0;
    @(negedge clk);
    #2;
    @(negedge clk);
    #2;
    d_read = 1'b0; d_address = 16'hFFFF;
    cnt = 0;
    repeat (12) begin
      if (d_resp) cnt++;
      @(negedge clk);
      #2;
    end
    checkOutput("drop_d_resp_count", cnt, 1);
    checkOutput("drop_back_idle", mem_read, 1'b0);

    // Back-to-back I reads against a one-cycle memory.
    mem_lat = 1;
    for (int k = 0; k < 4; k++) exp_q.push_back('{1'b0, 16'(16'h1000 + k * 16), '0, REQ_I});
    @(negedge clk);
    #2;
    i_read = 1'b1; i_address = 16'h1000;
    cnt = 0;
    for (int c = 0; c < 40 && cnt < 4; c++) begin
      @(negedge clk);
      #2;
      if (i_resp) begin
        cnt++;
        i_address = 16'(16'h1000 + cnt * 16);
        if (cnt == 4) i_read = 1'b0;
      end
    end
    i_read = 1'b0;
    checkOutput("b2b_resp_count", cnt, 4);

    // Reset in the middle of a D write drops it silently.
    repeat (2) @(negedge clk);
    chk_en = 1'b0;
    mem_lat = 100;
    @(negedge clk);
    #2;
    d_write = 1'b1; d_address = 16'h0200; d_wdata = 128'hBEEF;
    found = 1'b0;
    for (int c = 0; c < 10 && !found; c++) begin
      @(negedge clk);
      #2;
      if (mem_write) found = 1'b1;
    end
    checkOutput("rst_txn_started", found, 1'b1);
    #1 rst_n = 1'b0;
    #1;
    checkOutput("rst_mid_mem_write", mem_write, 1'b0);
    checkOutput("rst_mid_mem_read", mem_read, 1'b0);
    checkOutput("rst_mid_d_resp", d_resp, 1'b0);
    checkOutput("rst_mid_state", dut.state_q, IDLE);
    d_write = 1'b0;
    cnt = 0;
    repeat (3) begin
      @(negedge clk);
      #2;
      if (d_resp) cnt++;
    end
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      #2;
      if (d_resp) cnt++;
    end
    checkOutput("rst_no_d_resp", cnt, 0);
    in_txn = 1'b0;
    prev_resp = 1'b0;
    mem_lat = 2;
    chk_en = 1'b1;
    post = '{1'b1, 1'b0, 16'h0C00, 128'h0, 1'b0, 1'b0, 16'h0000, 128'h0, REQ_I};
    applyStimulus(post);

    repeat (3) @(negedge clk);
    checkOutput("queue_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
